// File: rtl/parking_pkg.sv
// Parking billing shared types and constants.
// State encoding, tariff defaults and BCD sizing helpers.
package parking_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV,
    S_CALC,
    S_BCD,
    S_DONE
  } state_t;

  localparam int DEF_CNT_W  = 21;
  localparam int DEF_TICKS  = 600;
  localparam int DEF_RATE0  = 2;
  localparam int DEF_RATE1  = 5;
  localparam int DEF_GRACE  = 0;
  localparam int DEF_NDIG   = 4;

  function automatic longint pow10(input int ndig);
    longint p;
    p = 1;
    for (int i = 0; i < ndig; i++) p = p * 10;
    return p;
  endfunction

  function automatic int maxv(input int ndig);
    return int'(pow10(ndig) - 1);
  endfunction

  function automatic int bin_w(input int ndig);
    return $clog2(pow10(ndig));
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter.
// One input bit is shifted in per cycle after start.
module bin2bcd_seq #(
  parameter int BIN_W = 14,
  parameter int NDIG  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                done,
  output logic [4*NDIG-1:0]   bcd
);

  localparam int CW = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]  sr;
  logic [4*NDIG-1:0] adj;
  logic [CW-1:0]     cnt;
  logic              busy;

  // add-3 correction on every digit of 5 or more before the shift
  always_comb begin
    adj = bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // load on start, then shift one bit per cycle until done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sr   <= bin;
        bcd  <= '0;
        cnt  <= CW'(BIN_W);
        busy <= 1'b1;
      end else if (busy) begin
        bcd <= {adj[4*NDIG-2:0], sr[BIN_W-1]};
        sr  <= {sr[BIN_W-2:0], 1'b0};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/parking_billing.sv
// Parking fee calculator: ticks -> units -> fee,
// presented as clamped BCD with a saturation flag.
module parking_billing
  import parking_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TICKS_PER_UNIT = DEF_TICKS,
  parameter int RATE0          = DEF_RATE0,
  parameter int RATE1          = DEF_RATE1,
  parameter int GRACE_UNITS    = DEF_GRACE,
  parameter int NDIG           = DEF_NDIG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CNT_W-1:0]  req_count,
  input  logic              req_mode,
  output logic              res_valid,
  output logic [4*NDIG-1:0] units_bcd,
  output logic [4*NDIG-1:0] fee_bcd,
  output logic              sat
);

  localparam int BW = bin_w(NDIG);
  localparam int MV = maxv(NDIG);
  localparam int WW = CNT_W + 32;
  localparam int CW = $clog2(CNT_W + 1);

  localparam logic [CNT_W:0]  DIVISOR = (CNT_W+1)'(TICKS_PER_UNIT);
  localparam logic [WW-1:0]   MAXW    = WW'(MV);
  localparam logic [WW-1:0]   GRACEW  = WW'(GRACE_UNITS);

  state_t            state;
  logic [CNT_W-1:0]  q;
  logic [CNT_W-1:0]  rem;
  logic [CW-1:0]     dcnt;
  logic              mode_r;
  logic              sat_pend;

  logic [CNT_W:0]    trial;
  logic              ge;
  logic [WW-1:0]     units_w;
  logic [WW-1:0]     bill_w;
  logic [WW-1:0]     rate_w;
  logic [WW-1:0]     fee_w;
  logic              u_sat;
  logic              f_sat;
  logic [BW-1:0]     u_cl;
  logic [BW-1:0]     f_cl;
  logic              start;
  logic              u_done;
  logic              f_done;
  logic [4*NDIG-1:0] u_bcd;
  logic [4*NDIG-1:0] f_bcd;

  // one restoring-division step and the tariff arithmetic
  always_comb begin
    trial   = {rem, q[CNT_W-1]};
    ge      = trial >= DIVISOR;
    units_w = WW'(q);
    bill_w  = (units_w > GRACEW) ? units_w - GRACEW : '0;
    rate_w  = mode_r ? WW'(RATE1) : WW'(RATE0);
    fee_w   = bill_w * rate_w;
    u_sat   = units_w > MAXW;
    f_sat   = fee_w > MAXW;
    u_cl    = u_sat ? BW'(MV) : BW'(units_w);
    f_cl    = f_sat ? BW'(MV) : BW'(fee_w);
    start   = state == S_CALC;
  end

  bin2bcd_seq #(.BIN_W(BW), .NDIG(NDIG)) u_units (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (u_cl),
    .done  (u_done),
    .bcd   (u_bcd)
  );

  bin2bcd_seq #(.BIN_W(BW), .NDIG(NDIG)) u_fee (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (f_cl),
    .done  (f_done),
    .bcd   (f_bcd)
  );

  // control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      res_valid <= 1'b0;
      sat       <= 1'b0;
      units_bcd <= '0;
      fee_bcd   <= '0;
      sat_pend  <= 1'b0;
      q         <= '0;
      rem       <= '0;
      mode_r    <= 1'b0;
      dcnt      <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (req_valid && req_ready) begin
            q         <= req_count;
            rem       <= '0;
            mode_r    <= req_mode;
            dcnt      <= CW'(CNT_W - 1);
            req_ready <= 1'b0;
            res_valid <= 1'b0;
            state     <= S_DIV;
          end
        end
        S_DIV: begin
          q    <= {q[CNT_W-2:0], ge};
          rem  <= ge ? CNT_W'(trial - DIVISOR) : CNT_W'(trial);
          dcnt <= dcnt - CW'(1);
          if (dcnt == '0) state <= S_CALC;
        end
        S_CALC: begin
          sat_pend <= u_sat | f_sat;
          state    <= S_BCD;
        end
        S_BCD: begin
          if (u_done && f_done) begin
            units_bcd <= u_bcd;
            fee_bcd   <= f_bcd;
            sat       <= sat_pend;
            res_valid <= 1'b1;
            req_ready <= 1'b1;
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_billing.sv
// Self-checking bench for parking_billing.
// Directed and random requests against an arithmetic model.
module tb_parking_billing;

  localparam int LAT = 37;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [20:0] req_count;
  logic        req_mode;
  logic        res_valid;
  logic [15:0] units_bcd;
  logic [15:0] fee_bcd;
  logic        sat;

  int n_checks = 0;
  int n_fail   = 0;

  parking_billing dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_count (req_count),
    .req_mode  (req_mode),
    .res_valid (res_valid),
    .units_bcd (units_bcd),
    .fee_bcd   (fee_bcd),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input longint v);
    logic [15:0] r;
    longint x;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model(input longint c, input bit m,
                       output logic [15:0] ub, output logic [15:0] fb,
                       output logic s);
    longint u, b, f;
    u = c / 600;
    b = (u > 0) ? u - 0 : 0;
    f = b * (m ? 5 : 2);
    s = (u > 9999) || (f > 9999);
    if (u > 9999) u = 9999;
    if (f > 9999) f = 9999;
    ub = to_bcd(u);
    fb = to_bcd(f);
  endtask

  task automatic run_req(input longint c, input bit m, output int lat,
                         output logic [15:0] ub, output logic [15:0] fb,
                         output logic s);
    @(negedge clk);
    req_valid = 1'b1;
    req_count = 21'(c);
    req_mode  = m;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    ub = units_bcd;
    fb = fee_bcd;
    s  = sat;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = 1'b0;
    req_count = '0;
    req_mode  = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 5;
    if (res_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b want 0", res_valid);
    end
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %b want 1", req_ready);
    end
    if (units_bcd !== 16'h0) begin
      n_fail++; $display("FAIL reset_units got %h want 0000", units_bcd);
    end
    if (fee_bcd !== 16'h0) begin
      n_fail++; $display("FAIL reset_fee got %h want 0000", fee_bcd);
    end
    if (sat !== 1'b0) begin
      n_fail++; $display("FAIL reset_sat got %b want 0", sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_req(input string nm, input longint c, input bit m);
    int lat;
    logic [15:0] ub, fb, eu, ef;
    logic s, es;
    model(c, m, eu, ef, es);
    run_req(c, m, lat, ub, fb, s);
    n_checks += 4;
    if (lat != LAT) begin
      n_fail++; $display("FAIL %s_lat got %0d want %0d", nm, lat, LAT);
    end
    if (ub !== eu) begin
      n_fail++; $display("FAIL %s_units got %h want %h", nm, ub, eu);
    end
    if (fb !== ef) begin
      n_fail++; $display("FAIL %s_fee got %h want %h", nm, fb, ef);
    end
    if (s !== es) begin
      n_fail++; $display("FAIL %s_sat got %b want %b", nm, s, es);
    end
  endtask

  task automatic test_directed();
    check_req("c599", 599, 1'b0);
    check_req("c7799", 7799, 1'b0);
    check_req("c600m1", 600, 1'b1);
    check_req("cmax", 2097151, 1'b1);
    check_req("c5999400", 5999399 % 2097152, 1'b1);
    n_checks += 3;
    if (units_bcd !== to_bcd(5999399 % 2097152 / 600)) begin
      n_fail++; $display("FAIL lit_units got %h", units_bcd);
    end
    check_req("c0", 0, 1'b1);
    if (fee_bcd !== 16'h0000) begin
      n_fail++; $display("FAIL lit_fee0 got %h want 0000", fee_bcd);
    end
    check_req("c1199", 1199, 1'b1);
    if (units_bcd !== 16'h0001) begin
      n_fail++; $display("FAIL lit_u1199 got %h want 0001", units_bcd);
    end
  endtask

  task automatic test_random();
    longint c;
    bit m;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 2))
        0: c = $urandom_range(0, 20000);
        1: c = $urandom_range(1190000, 1210000);
        default: c = $urandom_range(0, 2097151);
      endcase
      m = 1'($urandom_range(0, 1));
      check_req("rand", c, m);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    logic [15:0] eu, ef;
    logic es;
    model(9000, 1'b1, eu, ef, es);
    @(negedge clk);
    req_valid = 1'b1;
    req_count = 21'd9000;
    req_mode  = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL busy_ready got %b want 0", req_ready);
    end
    while (res_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_count = 21'($urandom);
      req_mode  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      lat++;
    end
    req_valid = 1'b0;
    n_checks += 3;
    if (lat != LAT) begin
      n_fail++; $display("FAIL busy_lat got %0d want %0d", lat, LAT);
    end
    if (units_bcd !== eu) begin
      n_fail++; $display("FAIL busy_units got %h want %h", units_bcd, eu);
    end
    if (fee_bcd !== ef) begin
      n_fail++; $display("FAIL busy_fee got %h want %h", fee_bcd, ef);
    end
  endtask

  task automatic test_reset_mid(input int wait_cyc);
    int seen;
    @(negedge clk);
    req_valid = 1'b1;
    req_count = 21'd123456;
    req_mode  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (wait_cyc) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks += 5;
    if (res_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_valid got %b want 0", res_valid);
    end
    if (units_bcd !== 16'h0) begin
      n_fail++; $display("FAIL mid_units got %h want 0000", units_bcd);
    end
    if (fee_bcd !== 16'h0) begin
      n_fail++; $display("FAIL mid_fee got %h want 0000", fee_bcd);
    end
    if (sat !== 1'b0) begin
      n_fail++; $display("FAIL mid_sat got %b want 0", sat);
    end
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_ready got %b want 1", req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (res_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL mid_partial got %0d want 0", seen);
    end
    check_req("after_rst", 60000, 1'b0);
  endtask

  task automatic test_back_to_back();
    int lat;
    check_req("b2b_first", 1200, 1'b0);
    n_checks += 2;
    if (units_bcd !== 16'h0002 || fee_bcd !== 16'h0004) begin
      n_fail++;
      $display("FAIL b2b_first_lit got %h/%h want 0002/0004",
               units_bcd, fee_bcd);
    end
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready got %b want 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_count = 21'd3000;
    req_mode  = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n_checks += 2;
    if (res_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drop got %b want 0", res_valid);
    end
    if (units_bcd !== 16'h0002) begin
      n_fail++; $display("FAIL b2b_hold got %h want 0002", units_bcd);
    end
    lat = 0;
    while (res_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_checks += 4;
    if (lat != LAT) begin
      n_fail++; $display("FAIL b2b_lat got %0d want %0d", lat, LAT);
    end
    if (units_bcd !== 16'h0005) begin
      n_fail++; $display("FAIL b2b_units got %h want 0005", units_bcd);
    end
    if (fee_bcd !== 16'h0010) begin
      n_fail++; $display("FAIL b2b_fee got %h want 0010", fee_bcd);
    end
    if (sat !== 1'b0) begin
      n_fail++; $display("FAIL b2b_sat got %b want 0", sat);
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (res_valid !== 1'b1 || units_bcd !== 16'h0005) begin
      n_fail++;
      $display("FAIL b2b_stable got %b/%h want 1/0005",
               res_valid, units_bcd);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_mid(10);
    test_reset_mid(30);
    test_back_to_back();
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parking_billing.md
PARKING_BILLING -- requirements
Module: parking_billing

Interface
REQ-001 Parameter CNT_W, default 21, width of the elapsed-tick count input.
REQ-002 Parameter TICKS_PER_UNIT, default 600, ticks per billable time unit.
REQ-003 Parameter RATE0, default 2, fee per billable unit in tariff mode 0.
REQ-004 Parameter RATE1, default 5, fee per billable unit in tariff mode 1.
REQ-005 Parameter GRACE_UNITS, default 0, leading time units billed at zero.
REQ-006 Parameter NDIG, default 4, BCD digits per displayed value.
REQ-007 Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
REQ-008 Request and result ports:
- req_valid  in  1  request strobe
- req_ready  out  1  block can accept a request
- req_count  in  CNT_W  elapsed ticks of one parking session
- req_mode  in  1  tariff select (0: RATE0, 1: RATE1)
- res_valid  out  1  result outputs valid
- units_bcd  out  4*NDIG  elapsed units, BCD, most-significant digit at the top
- fee_bcd  out  4*NDIG  fee, BCD, most-significant digit at the top
- sat  out  1  units or fee was clamped

Function
REQ-009 A request is accepted on a rising edge where req_valid=1 and req_ready=1; req_count and req_mode are captured on that edge.
REQ-010 req_ready shall be 1 in IDLE and DONE and 0 in every other state.
REQ-011 FSM states: IDLE, DIV, CALC, BCD, DONE; IDLE->DIV on accept; DIV->CALC after CNT_W cycles; CALC->BCD after 1 cycle; BCD->DONE after BIN_W cycles; DONE->DIV on accept, otherwise DONE holds.
REQ-012 In DIV, units = floor(req_count / TICKS_PER_UNIT) by restoring division, one quotient bit per cycle.
REQ-013 In CALC, billable = units - GRACE_UNITS when units > GRACE_UNITS, else 0; fee = billable * (req_mode ? RATE1 : RATE0), computed without truncation.
REQ-014 In CALC, units and fee shall each be clamped to MAXV = 10^NDIG - 1; sat = 1 if either value was clamped.
REQ-015 In BCD, both clamped values shall be converted by double-dabble in parallel, one bit per cycle, for BIN_W = ceil(log2(10^NDIG)) cycles.
REQ-016 res_valid shall be 1 only in DONE; units_bcd, fee_bcd and sat shall be stable while res_valid=1.
REQ-017 Latency: res_valid rises exactly CNT_W + 1 + BIN_W + 1 cycles after the accept edge (37 at defaults).
REQ-018 An accept in DONE shall drop res_valid on the next cycle; outputs keep the old result until the new DONE.
REQ-019 req_valid while req_ready=0 shall be ignored without side effects.

Reset
REQ-020 On a rising edge with rst_n=0, the FSM enters IDLE; res_valid=0, sat=0, units_bcd=0, fee_bcd=0; req_ready=1 from the next cycle.
REQ-021 Reset in any state, including mid-DIV or mid-BCD, abandons the computation; no partial result is ever presented.

Structure
REQ-022 Package parking_pkg shall hold the state enum, the BIN_W and MAXV constant functions, and the default tariff constants.
REQ-023 The conversion shall be a sub-module bin2bcd_seq (start/done, BIN_W in, 4*NDIG out), instantiated twice.

Verification (defaults)
REQ-024 req_count=599, mode 0 -> units_bcd=0000, fee_bcd=0000, sat=0, res_valid 37 cycles after accept.
REQ-025 req_count=7799, mode 0 -> units_bcd=0012, fee_bcd=0024, sat=0.
REQ-026 req_count=600, mode 1 -> units_bcd=0001, fee_bcd=0005, sat=0.
REQ-027 req_count=2097151, mode 1 -> units_bcd=3495, fee_bcd=9999, sat=1.
REQ-028 rst_n=0 for 1 cycle, 10 cycles into DIV -> res_valid=0, outputs 0, req_ready=1; a new request then completes correctly.
REQ-029 Back-to-back: 1200 mode 0, then 3000 mode 0 accepted in DONE -> 0002/0004, res_valid low 37 cycles, then 0005/0010.
